pose_animator: RTL and testbench

Upstream companion to the triangle sprite renderer. Accepts rover pose measurements (signed screen X/Y, 15° orientation index) over a valid/ready handshake and produces the `center_x`, `center_y` and `orientation` the renderer draws from. Outputs change only once per video frame, moving toward the latest measured pose at a bounded rate: at most `MAX_STEP` pixels per axis per frame, and one 15° step every `HOLD_FRAMES` frames. The sprite therefore glides rather than jumps, and never tears mid-frame.

---
 rtl/pose_animator_pkg.sv | 33 +++
 rtl/pose_animator_if.sv | 13 +
 rtl/pose_animator_axis_stepper.sv | 28 ++
 rtl/pose_animator.sv | 120 ++++++++++++
 tb/tb_pose_animator.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pose_animator_pkg.sv
// Shared constants, FSM encoding and orientation helper for the pose animator.
package pose_animator_pkg;

  localparam int ORIENT_STEPS = 24;
  localparam int COORD_W      = 12;
  localparam int ORIENT_W     = 5;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    UPDATE     = 2'd1,
    COMMIT     = 2'd2
  } state_t;

  // One 15-degree step from cur toward tgt along the shorter arc. An exact
  // half-turn (diff 12) resolves to +1. Returns cur unchanged when equal.
  function automatic logic [ORIENT_W-1:0] orient_toward(
    input logic [ORIENT_W-1:0] cur,
    input logic [ORIENT_W-1:0] tgt
  );
    logic [ORIENT_W:0]   diff;
    logic [ORIENT_W-1:0] res;
    if (tgt >= cur) diff = {1'b0, tgt} - {1'b0, cur};
    else            diff = {1'b0, tgt} + (ORIENT_W+1)'(ORIENT_STEPS) - {1'b0, cur};
    if (diff == '0)
      res = cur;
    else if (diff <= (ORIENT_W+1)'(ORIENT_STEPS / 2))
      res = (cur == ORIENT_W'(ORIENT_STEPS - 1)) ? '0 : cur + ORIENT_W'(1);
    else
      res = (cur == '0) ? ORIENT_W'(ORIENT_STEPS - 1) : cur - ORIENT_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/pose_animator_if.sv
// Measurement valid/ready channel carrying one rover pose sample.
interface pose_animator_if;
  import pose_animator_pkg::*;

  logic                       meas_valid;
  logic                       meas_ready;
  logic signed [COORD_W-1:0]  meas_x;
  logic signed [COORD_W-1:0]  meas_y;
  logic        [ORIENT_W-1:0] meas_orient;

  modport master (output meas_valid, meas_x, meas_y, meas_orient, input meas_ready);
  modport slave  (input meas_valid, meas_x, meas_y, meas_orient, output meas_ready);
endinterface

// File: rtl/pose_animator_axis_stepper.sv
// Combinational one-axis stepper: moves cur toward tgt by at most max_step.
module axis_stepper
  import pose_animator_pkg::*;
(
  input  logic signed [COORD_W-1:0] cur_i,
  input  logic signed [COORD_W-1:0] tgt_i,
  input  logic        [7:0]         max_step_i,
  output logic signed [COORD_W-1:0] nxt_o
);

  // One extra bit so the difference of any two 12-bit coordinates fits.
  logic signed [COORD_W:0] diff;
  logic signed [COORD_W:0] mag;
  logic signed [COORD_W:0] step;

  // Snap when within reach, otherwise take a full step in the sign of diff.
  always_comb begin
    diff  = {tgt_i[COORD_W-1], tgt_i} - {cur_i[COORD_W-1], cur_i};
    mag   = diff[COORD_W] ? -diff : diff;
    step  = {{(COORD_W-7){1'b0}}, max_step_i};
    nxt_o = tgt_i;
    if (mag > step) begin
      if (diff[COORD_W]) nxt_o = cur_i - step[COORD_W-1:0];
      else               nxt_o = cur_i + step[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/pose_animator.sv
// Frame-synchronous pose animator: latches the latest measurement as target
// and glides the displayed pose toward it once per video frame.
module pose_animator
  import pose_animator_pkg::*;
#(
  parameter int MAX_STEP    = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int HOME_X      = 512,
  parameter int HOME_Y      = 384
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  pose_animator_if.slave             meas_if,
  output logic signed [COORD_W-1:0]  center_x,
  output logic signed [COORD_W-1:0]  center_y,
  output logic        [ORIENT_W-1:0] orientation,
  output logic                       moving,
  output logic                       orient_err
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_FRAMES - 1);
  localparam logic signed [COORD_W-1:0] HOME_X_C = COORD_W'(HOME_X);
  localparam logic signed [COORD_W-1:0] HOME_Y_C = COORD_W'(HOME_Y);

  state_t                     state_q;
  logic                       ready_q;
  logic signed [COORD_W-1:0]  tgt_x_q, tgt_y_q, nxt_x_q, nxt_y_q, center_x_q, center_y_q;
  logic        [ORIENT_W-1:0] tgt_o_q, nxt_o_q, orient_q;
  logic        [3:0]          hold_q;
  logic                       moving_q, orient_err_q;

  logic signed [COORD_W-1:0]  step_x_d, step_y_d;
  logic        [ORIENT_W-1:0] step_o_d;
  logic                       xfer;

  assign xfer     = meas_if.meas_valid && ready_q;
  assign step_o_d = orient_toward(orient_q, tgt_o_q);

  axis_stepper u_step_x (
    .cur_i(center_x_q), .tgt_i(tgt_x_q), .max_step_i(8'(MAX_STEP)), .nxt_o(step_x_d)
  );
  axis_stepper u_step_y (
    .cur_i(center_y_q), .tgt_i(tgt_y_q), .max_step_i(8'(MAX_STEP)), .nxt_o(step_y_d)
  );

  // Frame FSM: accept measurements while waiting, compute, then commit outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      ready_q      <= 1'b0;
      tgt_x_q      <= HOME_X_C;
      tgt_y_q      <= HOME_Y_C;
      tgt_o_q      <= '0;
      nxt_x_q      <= HOME_X_C;
      nxt_y_q      <= HOME_Y_C;
      nxt_o_q      <= '0;
      center_x_q   <= HOME_X_C;
      center_y_q   <= HOME_Y_C;
      orient_q     <= '0;
      hold_q       <= '0;
      moving_q     <= 1'b0;
      orient_err_q <= 1'b0;
    end else begin
      orient_err_q <= xfer && (meas_if.meas_orient >= ORIENT_W'(ORIENT_STEPS));
      if (xfer) begin
        tgt_x_q <= meas_if.meas_x;
        tgt_y_q <= meas_if.meas_y;
        if (meas_if.meas_orient < ORIENT_W'(ORIENT_STEPS)) tgt_o_q <= meas_if.meas_orient;
      end
      case (state_q)
        WAIT_FRAME: begin
          if (frame_start) begin
            state_q <= UPDATE;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        UPDATE: begin
          nxt_x_q <= step_x_d;
          nxt_y_q <= step_y_d;
          nxt_o_q <= orient_q;
          if (orient_q != tgt_o_q) begin
            if (hold_q == HOLD_LAST) begin
              nxt_o_q <= step_o_d;
              hold_q  <= '0;
            end else begin
              hold_q  <= hold_q + 4'd1;
            end
          end else begin
            hold_q <= '0;
          end
          state_q <= COMMIT;
          ready_q <= 1'b0;
        end
        COMMIT: begin
          center_x_q <= nxt_x_q;
          center_y_q <= nxt_y_q;
          orient_q   <= nxt_o_q;
          moving_q   <= (nxt_x_q != tgt_x_q) || (nxt_y_q != tgt_y_q) || (nxt_o_q != tgt_o_q);
          state_q    <= WAIT_FRAME;
          ready_q    <= 1'b1;
        end
        default: begin
          state_q <= WAIT_FRAME;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign meas_if.meas_ready = ready_q;
  assign center_x           = center_x_q;
  assign center_y           = center_y_q;
  assign orientation        = orient_q;
  assign moving             = moving_q;
  assign orient_err         = orient_err_q;

endmodule

// File: tb/tb_pose_animator.sv
// Self-checking bench for pose_animator: directed spec scenarios followed by
// randomized measurements, checked against an integer pose model.
module tb_pose_animator;
  import pose_animator_pkg::*;

  localparam int MAX_STEP = 4;
  localparam int HOLD     = 2;
  localparam int HX       = 512;
  localparam int HY       = 384;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic signed [COORD_W-1:0]  center_x, center_y;
  logic        [ORIENT_W-1:0] orientation;
  logic moving, orient_err;

  always #5 clk = ~clk;

  pose_animator_if ifc ();

  pose_animator #(.MAX_STEP(MAX_STEP), .HOLD_FRAMES(HOLD), .HOME_X(HX), .HOME_Y(HY)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .meas_if(ifc),
    .center_x(center_x), .center_y(center_y), .orientation(orientation),
    .moving(moving), .orient_err(orient_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference pose model (plain integers)
  int mx, my, mo, mtx, mty, mto, mhold;
  int mmov;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mx = HX; my = HY; mo = 0; mtx = HX; mty = HY; mto = 0; mhold = 0; mmov = 0;
  endtask

  function automatic int approach(input int c, input int t);
    int d = t - c;
    if (d <= MAX_STEP && d >= -MAX_STEP) return t;
    return (d > 0) ? c + MAX_STEP : c - MAX_STEP;
  endfunction

  task automatic model_frame();
    int diff;
    mx = approach(mx, mtx);
    my = approach(my, mty);
    if (mo != mto) begin
      if (mhold == HOLD - 1) begin
        diff  = ((mto - mo) % 24 + 24) % 24;
        mo    = (diff <= 12) ? (mo + 1) % 24 : (mo + 23) % 24;
        mhold = 0;
      end else begin
        mhold++;
      end
    end else begin
      mhold = 0;
    end
    mmov = ((mx != mtx) || (my != mty) || (mo != mto)) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".x"}, int'(center_x), mx);
    check({tag, ".y"}, int'(center_y), my);
    check({tag, ".o"}, int'(orientation), mo);
    check({tag, ".mov"}, int'(moving), mmov);
  endtask

  task automatic drive_meas(input int x, input int y, input int o);
    ifc.meas_x      = x[COORD_W-1:0];
    ifc.meas_y      = y[COORD_W-1:0];
    ifc.meas_orient = o[ORIENT_W-1:0];
  endtask

  task automatic model_accept(input int x, input int y, input int o);
    mtx = x; mty = y;
    if (o < 24) mto = o;
  endtask

  task automatic send_meas(input int x, input int y, input int o);
    int w = 0;
    ifc.meas_valid = 1'b1;
    drive_meas(x, y, o);
    while (!ifc.meas_ready && w < 8) begin step(); w++; end
    if (w == 8) check("ready_timeout", 0, 1);
    step();
    ifc.meas_valid = 1'b0;
    model_accept(x, y, o);
    check("orient_err_pulse", int'(orient_err), (o >= 24) ? 1 : 0);
    step();
    check("orient_err_clear", int'(orient_err), 0);
  endtask

  // One frame: pulse (or hold for 3 cycles) frame_start and check the timeline.
  task automatic do_frame(input string tag, input bit hold_fs);
    frame_start = 1'b1;
    step();
    if (!hold_fs) frame_start = 1'b0;
    check({tag, ".rdy_upd"}, int'(ifc.meas_ready), 0);
    check({tag, ".x_hold"}, int'(center_x), mx);
    step();
    check({tag, ".rdy_cmt"}, int'(ifc.meas_ready), 0);
    step();
    frame_start = 1'b0;
    model_frame();
    check_outputs(tag);
    check({tag, ".rdy_wait"}, int'(ifc.meas_ready), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rdy_in_reset", int'(ifc.meas_ready), 0);
    reset = 1'b0;
    model_reset();
    check_outputs("reset");
    check("err_reset", int'(orient_err), 0);
    step();
    check("rdy_after_reset", int'(ifc.meas_ready), 1);
  endtask

  initial begin
    int x, y, o, nf;
    ifc.meas_valid = 1'b0;
    drive_meas(0, 0, 0);
    model_reset();

    // Idle frames
    do_reset();
    for (int i = 0; i < 3; i++) do_frame("idle", 1'b0);

    // Position glide toward (530, 380)
    send_meas(530, 380, 0);
    do_frame("glide1", 1'b0);
    check("glide1_x_const", int'(center_x), 516);
    check("glide1_y_const", int'(center_y), 380);
    for (int i = 0; i < 4; i++) do_frame("glide", 1'b0);
    check("glide_x_final", int'(center_x), 530);
    check("glide_mov_final", int'(moving), 0);

    // Orientation short arc 0 -> 22 via 23
    send_meas(530, 380, 22);
    do_frame("rot1", 1'b0);
    do_frame("rot2", 1'b0);
    check("rot2_const", int'(orientation), 23);
    do_frame("rot3", 1'b1);
    do_frame("rot4", 1'b0);
    check("rot4_const", int'(orientation), 22);
    send_meas(530, 380, 0);
    for (int i = 0; i < 5; i++) do_frame("rot_back", 1'b0);
    send_meas(530, 380, 12);
    do_frame("half1", 1'b0);
    do_frame("half2", 1'b0);
    check("half_const", int'(orientation), 1);

    // Transfer coincident with frame_start, then a valid held through UPDATE/COMMIT
    do_reset();
    ifc.meas_valid = 1'b1;
    drive_meas(600, HY, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    model_accept(600, HY, 0);
    drive_meas(100, HY, 0);
    check("sim_rdy_upd", int'(ifc.meas_ready), 0);
    step();
    check("sim_rdy_cmt", int'(ifc.meas_ready), 0);
    step();
    model_frame();
    check_outputs("sim");
    check("sim_x_const", int'(center_x), 516);
    step();
    ifc.meas_valid = 1'b0;
    model_accept(100, HY, 0);
    do_frame("held", 1'b0);
    check("held_x_const", int'(center_x), 512);

    // Out-of-range orientation with extreme X target
    send_meas(-2048, HY, 27);
    for (int i = 0; i < 3; i++) do_frame("neg", 1'b0);
    check("neg_x_const", int'(center_x), 500);

    // Reset during UPDATE
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check_outputs("rst_upd");
    check("rst_upd_rdy", int'(ifc.meas_ready), 0);
    step();
    check("rst_upd_rdy_after", int'(ifc.meas_ready), 1);

    // Randomized measurements and frames
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 2) == 0) begin
          x = mx + int'($urandom_range(0, 10)) - 5;
          y = my + int'($urandom_range(0, 10)) - 5;
          if (x > 2047) x = 2047;
          if (x < -2048) x = -2048;
          if (y > 2047) y = 2047;
          if (y < -2048) y = -2048;
        end else begin
          x = int'($urandom_range(0, 4095)) - 2048;
          y = int'($urandom_range(0, 4095)) - 2048;
        end
        o = int'($urandom_range(0, 27));
        send_meas(x, y, o);
      end
      nf = int'($urandom_range(1, 3));
      for (int f = 0; f < nf; f++) do_frame("rand", ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
